// File: rtl/aos_pkg.sv
// aos_pkg: shared constants and the AR/AW slice payload type for the AOS transaction limiter.
package aos_pkg;
    localparam int AOS_BEAT_BYTES = 64;
    localparam logic [2:0] AOS_BEAT_SIZE = 3'b110;
    localparam int AOS_CNT_W = 8;
    localparam int AOS_ID_W = 4;
    localparam int AOS_ADDR_W = 32;
    localparam int AOS_DATA_W = AOS_BEAT_BYTES * 8;
    typedef struct packed {
        logic [AOS_ID_W-1:0] id;
        logic [AOS_ADDR_W-1:0] addr;
        logic [7:0] len;
        logic [2:0] size;
    } ax_t;
endpackage

// File: rtl/aos_txn_limiter_if.sv
// axi_bus_t: single-beat AXI bundle; modports are named for the side of the limiter they face.
interface axi_bus_t;
    import aos_pkg::*;
    logic arvalid, arready;
    logic [AOS_ID_W-1:0] arid;
    logic [AOS_ADDR_W-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic awvalid, awready;
    logic [AOS_ID_W-1:0] awid;
    logic [AOS_ADDR_W-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic wvalid, wready, wlast;
    logic [AOS_DATA_W-1:0] wdata;
    logic [AOS_DATA_W/8-1:0] wstrb;
    logic rvalid, rready, rlast;
    logic [AOS_ID_W-1:0] rid;
    logic [AOS_DATA_W-1:0] rdata;
    logic [1:0] rresp;
    logic bvalid, bready;
    logic [AOS_ID_W-1:0] bid;
    logic [1:0] bresp;
    modport master (
        input arvalid, arid, araddr, arlen, arsize, output arready,
        input awvalid, awid, awaddr, awlen, awsize, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output rvalid, rid, rdata, rresp, rlast, input rready,
        output bvalid, bid, bresp, input bready
    );
    modport slave (
        output arvalid, arid, araddr, arlen, arsize, input arready,
        output awvalid, awid, awaddr, awlen, awsize, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input rvalid, rid, rdata, rresp, rlast, output rready,
        input bvalid, bid, bresp, output bready
    );
endinterface

// File: rtl/aos_credit_counter.sv
// aos_credit_counter: outstanding-transaction count with MAX limit and underflow detect.
module aos_credit_counter import aos_pkg::*; #(
    parameter int MAX = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic [AOS_CNT_W-1:0] count,
    output logic avail,
    output logic underflow
);
    assign avail = count < AOS_CNT_W'(MAX);
    assign underflow = dec && count == '0;
    // an unexpected response is ignored, so a same-cycle issue still counts
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else count <= count + AOS_CNT_W'(inc) - AOS_CNT_W'(dec && !underflow);
endmodule

// File: rtl/aos_txn_limiter.sv
// aos_txn_limiter: caps outstanding single-beat reads and writes with credit-gated
// AR/AW register slices; W, R and B pass straight through.
module aos_txn_limiter import aos_pkg::*; #(
    parameter int MAX_RD_OUT = 32,
    parameter int MAX_WR_OUT = 32
) (
    input  logic clk,
    input  logic rst,
    axi_bus_t.master axi_m,
    axi_bus_t.slave axi_s,
    output logic [AOS_CNT_W-1:0] rd_outstanding,
    output logic [AOS_CNT_W-1:0] wr_outstanding,
    output logic idle,
    output logic resp_err
);
    ax_t ar_q, aw_q;
    logic ar_full, aw_full, rd_avail, wr_avail, rd_uf, wr_uf;
    assign axi_s.arvalid = ar_full && rd_avail;
    assign axi_m.arready = !ar_full || (axi_s.arready && rd_avail);
    assign {axi_s.arid, axi_s.araddr, axi_s.arlen, axi_s.arsize} = ar_q;
    assign axi_s.awvalid = aw_full && wr_avail;
    assign axi_m.awready = !aw_full || (axi_s.awready && wr_avail);
    assign {axi_s.awid, axi_s.awaddr, axi_s.awlen, axi_s.awsize} = aw_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ar_full <= 1'b0;
            ar_q <= '0;
        end else if (axi_m.arvalid && axi_m.arready) begin
            ar_full <= 1'b1;
            ar_q <= {axi_m.arid, axi_m.araddr, axi_m.arlen, axi_m.arsize};
        end else if (axi_s.arvalid && axi_s.arready) ar_full <= 1'b0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            aw_full <= 1'b0;
            aw_q <= '0;
        end else if (axi_m.awvalid && axi_m.awready) begin
            aw_full <= 1'b1;
            aw_q <= {axi_m.awid, axi_m.awaddr, axi_m.awlen, axi_m.awsize};
        end else if (axi_s.awvalid && axi_s.awready) aw_full <= 1'b0;
    assign axi_s.wvalid = axi_m.wvalid;
    assign axi_s.wdata = axi_m.wdata;
    assign axi_s.wstrb = axi_m.wstrb;
    assign axi_s.wlast = 1'b1;
    assign axi_m.wready = axi_s.wready;
    assign axi_m.rvalid = axi_s.rvalid;
    assign axi_m.rid = axi_s.rid;
    assign axi_m.rdata = axi_s.rdata;
    assign axi_m.rresp = axi_s.rresp;
    assign axi_m.rlast = 1'b1;
    assign axi_s.rready = axi_m.rready;
    assign axi_m.bvalid = axi_s.bvalid;
    assign axi_m.bid = axi_s.bid;
    assign axi_m.bresp = axi_s.bresp;
    assign axi_s.bready = axi_m.bready;
    aos_credit_counter #(.MAX(MAX_RD_OUT)) u_rd_cnt (
        .clk(clk), .rst(rst),
        .inc(axi_s.arvalid && axi_s.arready),
        .dec(axi_s.rvalid && axi_s.rready),
        .count(rd_outstanding), .avail(rd_avail), .underflow(rd_uf)
    );
    aos_credit_counter #(.MAX(MAX_WR_OUT)) u_wr_cnt (
        .clk(clk), .rst(rst),
        .inc(axi_s.awvalid && axi_s.awready),
        .dec(axi_s.bvalid && axi_s.bready),
        .count(wr_outstanding), .avail(wr_avail), .underflow(wr_uf)
    );
    assign idle = rd_outstanding == '0 && wr_outstanding == '0 && !ar_full && !aw_full;
    always_ff @(posedge clk or posedge rst)
        if (rst) resp_err <= 1'b0;
        else resp_err <= resp_err || rd_uf || wr_uf;
endmodule
